// File: rtl/mpu_matrix_streamer.sv
// -----------------------------------------------------------------------------
// mpu_matrix_streamer
//   Output end of the MPU matrix path. On an accepted start the whole packed
//   ROWSxCOLS matrix is captured into a shadow register. It is then streamed out
//   one element per valid/ready beat, in row-major order, with row/col tags and
//   a last flag. A one-cycle done pulse follows acceptance of the final beat.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   start_i      capture matrix_i and begin streaming (honoured in IDLE only)
//   matrix_i     packed matrix, elem(r,c) at [WIDTH*(r+ROWS*c) +: WIDTH]
//   out_ready_i  consumer accepts the current beat when out_valid_o is high
//   busy_o       high while a matrix is being streamed
//   out_valid_o  out_data_o/out_row_o/out_col_o/out_last_o are valid
//   out_data_o   element value, passed through unmodified
//   out_row_o    row index of the current element
//   out_col_o    column index of the current element
//   out_last_o   high on the final element (ROWS-1, COLS-1)
//   done_o       one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module mpu_matrix_streamer #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ROWS*COLS*WIDTH-1:0]  matrix_i,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        out_valid_o,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [2:0]                  out_row_o,
  output logic [2:0]                  out_col_o,
  output logic                        out_last_o,
  output logic                        done_o
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Matrix storage is column-major: element (r,c) sits at linear slot r+ROWS*c.
  function automatic logic [WIDTH-1:0] elem_sel(
    input logic [ROWS*COLS*WIDTH-1:0] m,
    input logic [2:0]                 r,
    input logic [2:0]                 c
  );
    int idx;
    idx = WIDTH * (int'(r) + ROWS * int'(c));
    return m[idx +: WIDTH];
  endfunction

  state_t                       state_q;
  logic [ROWS*COLS*WIDTH-1:0]   cap_q;
  logic                         busy_q;
  logic                         valid_q;
  logic [WIDTH-1:0]             data_q;
  logic [2:0]                   row_q;
  logic [2:0]                   col_q;
  logic                         last_q;
  logic                         done_q;

  logic                         accept;
  logic [2:0]                   row_d;
  logic [2:0]                   col_d;
  logic                         last_d;
  logic [WIDTH-1:0]             data_d;

  // Next beat position and its element, used when the current beat is accepted.
  always_comb begin
    accept = valid_q & out_ready_i;
    if (col_q == LAST_COL) begin
      col_d = 3'd0;
      row_d = row_q + 3'd1;
    end else begin
      col_d = col_q + 3'd1;
      row_d = row_q;
    end
    last_d = (row_d == LAST_ROW) && (col_d == LAST_COL);
    data_d = elem_sel(cap_q, row_d, col_d);
  end

  // Streaming FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            // First beat comes straight from the input so it is presented
            // one cycle after start.
            cap_q   <= matrix_i;
            state_q <= ST_SEND;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            data_q  <= elem_sel(matrix_i, 3'd0, 3'd0);
            last_q  <= (LAST_ROW == 3'd0) && (LAST_COL == 3'd0);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (accept && last_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (accept) begin
            row_q  <= row_d;
            col_q  <= col_d;
            data_q <= data_d;
            last_q <= last_d;
          end else begin
            // Stalled: every output holds.
            state_q <= ST_SEND;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          data_q  <= '0;
          row_q   <= 3'd0;
          col_q   <= 3'd0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;
  assign out_last_o  = last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// -----------------------------------------------------------------------------
// tb_mpu_matrix_streamer
//   Directed bench for mpu_matrix_streamer. A table of per-cycle records covers
//   the basic full-rate stream; hand-written sequences cover backpressure,
//   start while busy, input changes after capture, async reset mid-stream and
//   bit-exact alternating data. Inputs change and outputs are sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_mpu_matrix_streamer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [199:0] matrix;
  logic         ready;
  logic         busy;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         out_last;
  logic         done;

  int checks = 0;
  int errors = 0;

  mpu_matrix_streamer #(.ROWS(5), .COLS(5), .WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .matrix_i    (matrix),
    .out_ready_i (ready),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .out_last_o  (out_last),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       ready;
    logic       busy;
    logic       valid;
    logic [7:0] data;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
    logic       done;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected element (r,c) for each matrix pattern used in the bench.
  function automatic logic [7:0] exp_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'(5 * r + c + 1);
      1:       return 8'hFF;
      2:       return (((5 * r + c) % 2) == 1) ? 8'hFF : 8'h00;
      default: return 8'(64 + 5 * r + c);
    endcase
  endfunction

  // Pack a pattern with elem(r,c) at bits [8*(r+5*c) +: 8].
  function automatic logic [199:0] build(input int mode);
    logic [199:0] m;
    m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m[8 * (r + 5 * c) +: 8] = exp_val(mode, r, c);
    return m;
  endfunction

  function automatic logic [31:0] outvec();
    return {14'd0, busy, out_valid, out_data, out_row, out_col, out_last, done};
  endfunction

  function automatic logic [31:0] mkvec(input logic b, input logic v, input logic [7:0] d,
                                        input logic [2:0] r, input logic [2:0] c,
                                        input logic l, input logic dn);
    return {14'd0, b, v, d, r, c, l, dn};
  endfunction

  // Called on the falling edge right after the start edge. Follows the stream
  // to completion and checks the done cycle.
  //   rdy_mode 0: ready always 1; 1: ready pattern 1,0,0,1
  //   hijack   1: start with an all-FF matrix at beat 10 and on the last beat
  //            2: scramble matrix input every cycle
  task automatic stream(input int mode, input int rdy_mode, input int hijack,
                        input string tag, output int busy_cycles);
    int          k;
    int          cyc;
    logic        prev_rdy;
    logic [31:0] prev_out;
    k = 0;
    cyc = 0;
    busy_cycles = 0;
    prev_rdy = 1'b1;
    prev_out = '0;
    while (k < 25 && cyc < 200) begin
      chk($sformatf("%s_beat%0d", tag, k), outvec(),
          mkvec(1'b1, 1'b1, exp_val(mode, k / 5, k % 5), 3'(k / 5), 3'(k % 5),
                (k == 24), 1'b0));
      if (!prev_rdy) chk($sformatf("%s_hold%0d", tag, k), outvec(), prev_out);
      if (busy) busy_cycles++;
      prev_out = outvec();
      if (rdy_mode == 1) ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else               ready = 1'b1;
      if (hijack == 1 && (k == 10 || k == 24)) begin
        start  = 1'b1;
        matrix = build(1);
      end else begin
        start = 1'b0;
      end
      if (hijack == 2)
        for (int j = 0; j < 25; j++) matrix[8 * j +: 8] = 8'($urandom);
      prev_rdy = ready;
      if (ready) k++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk({tag, "_timeout"}, 32'(cyc), 32'd0);
    chk({tag, "_done"}, outvec(), mkvec(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1));
    start = 1'b0;
  endtask

  task automatic kick(input int mode);
    start  = 1'b1;
    matrix = build(mode);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bc;

    // Test 1 vectors: idle, start, 25 beats at full rate, done, idle.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0};
    for (int k = 0; k < 25; k++)
      tbl[k + 1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'(k + 1), 3'(k / 5), 3'(k % 5), (k == 24), 1'b0};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[27] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    ready  = 1'b0;
    matrix = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", outvec(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 28; i++) begin
      chk($sformatf("t1_vec%0d", i), outvec(),
          mkvec(tbl[i].busy, tbl[i].valid, tbl[i].data, tbl[i].row, tbl[i].col,
                tbl[i].last, tbl[i].done));
      start  = tbl[i].start;
      ready  = tbl[i].ready;
      matrix = build(0);
      @(negedge clk);
    end

    // Test 2: backpressure.
    kick(0);
    stream(0, 1, 0, "t2", bc);
    @(negedge clk);
    chk("t2_done_drop", 32'(done), 32'd0);

    // Test 3: start while busy ignored, start in done cycle accepted.
    kick(0);
    stream(0, 0, 1, "t3a", bc);
    start  = 1'b1;
    matrix = build(1);
    @(negedge clk);
    start = 1'b0;
    stream(1, 0, 0, "t3b", bc);
    @(negedge clk);

    // Test 4: matrix input changes after capture are ignored.
    kick(3);
    stream(3, 0, 2, "t4", bc);
    @(negedge clk);

    // Test 5: async reset mid-stream, then a fresh stream.
    ready = 1'b1;
    kick(3);
    repeat (12) @(negedge clk);
    chk("t5_beat12", outvec(), mkvec(1'b1, 1'b1, exp_val(3, 2, 2), 3'd2, 3'd2, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1 chk("t5_async_clear", outvec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_done", outvec(), 32'd0);
    kick(0);
    stream(0, 0, 0, "t5", bc);
    @(negedge clk);

    // Test 6: alternating 00/FF, busy width and done width.
    kick(2);
    stream(2, 0, 0, "t6", bc);
    chk("t6_busy_cycles", 32'(bc), 32'd25);
    @(negedge clk);
    chk("t6_done_width", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
